// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_pkg
// Description : Shared state encoding, default widths and sizing helpers for
//               the serial configuration sequencer.
// Revision    : 1.0
// ============================================================================
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        ST_PGRST = 3'd0,
        ST_IDLE  = 3'd1,
        ST_GRST  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_GAP   = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_DATA_W         = 30;
    localparam int DEF_NUM_WORDS      = 4;
    localparam int DEF_DIV            = 128;
    localparam int DEF_GRST_BITS      = 40;
    localparam int DEF_GAP_BITS       = 4;
    localparam int DEF_DATA_MSB_FIRST = 0;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_sequencer_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_timer
// Description : Clock-enable bit divider; flags the last cycle of each bit
//               and produces the registered serial clock.
// Revision    : 1.0
// ============================================================================
module spi_bit_timer #(
    parameter int DIV = 128
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sck_en,
    output logic bit_end,
    output logic sck
);
    localparam int CNT_W = $clog2(2 * DIV);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = '0;
        if (en && (r_cnt != C_LAST)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // SCK is decoded from the next count so the flop is high exactly while
    // the count sits in the upper half of the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            sck   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            sck   <= sck_en && (w_cnt_nxt >= C_HALF);
        end
    end

    assign bit_end = en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_sequencer
// Description : Table-driven serial configuration sequencer (GRST, slave
//               address, data and idle gap per word).
// Revision    : 1.0
// ============================================================================
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_WORDS      = DEF_NUM_WORDS,
    parameter int DIV            = DEF_DIV,
    parameter int GRST_BITS      = DEF_GRST_BITS,
    parameter int GAP_BITS       = DEF_GAP_BITS,
    parameter int DATA_MSB_FIRST = DEF_DATA_MSB_FIRST
) (
    input  logic                              SCLK,
    input  logic                              RST,
    input  logic                              tbl_we,
    input  logic [idx_width(NUM_WORDS)-1:0]   tbl_addr,
    input  logic [ADDR_W+DATA_W-1:0]          tbl_wdata,
    input  logic [idx_width(NUM_WORDS):0]     num_words,
    input  logic                              start,
    input  logic                              rst_chip,
    output logic                              busy,
    output logic                              done,
    output logic [idx_width(NUM_WORDS)-1:0]   word_idx,
    output logic                              GRST,
    output logic                              REGSEL,
    output logic                              SIN,
    output logic                              SCK_O
);
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int BIT_W = $clog2(imax(imax(GRST_BITS, GAP_BITS), imax(ADDR_W, DATA_W)) + 1);
    localparam int AI_W  = idx_width(ADDR_W);
    localparam int DI_W  = idx_width(DATA_W);
    localparam logic [IDX_W:0] C_NW_MAX = (IDX_W + 1)'(NUM_WORDS);

    state_t             r_state, w_state_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W:0]     r_nw, w_nw_nxt, w_nw_clamp;
    logic [ENT_W-1:0]   r_tbl [NUM_WORDS];
    logic [ENT_W-1:0]   w_entry;
    logic [ADDR_W-1:0]  w_slave;
    logic [DATA_W-1:0]  w_data;
    logic [AI_W-1:0]    w_aidx;
    logic [DI_W-1:0]    w_didx;
    logic               w_we, w_word_end, w_last_word, w_bit_end;
    logic               w_grst_nxt, w_regsel_nxt, w_sin_nxt;

    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done     = (r_state == ST_FIN);
    assign word_idx = r_idx;

    assign w_we        = tbl_we && !busy && ({1'b0, tbl_addr} < C_NW_MAX);
    assign w_nw_clamp  = (num_words > C_NW_MAX) ? C_NW_MAX : num_words;
    assign w_last_word = (({1'b0, r_idx} + 1'b1) >= r_nw);

    spi_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk     (SCLK),
        .rst_n   (RST),
        .en      (busy),
        .sck_en  ((r_state == ST_PGRST) || (r_state == ST_GRST) ||
                  (r_state == ST_ADDR)  || (r_state == ST_DATA)),
        .bit_end (w_bit_end),
        .sck     (SCK_O)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_nw_nxt    = r_nw;
        w_word_end  = 1'b0;
        case (r_state)
            ST_PGRST, ST_GRST: begin
                if (w_bit_end) begin
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == BIT_W'(GRST_BITS - 1)) begin
                        w_bit_nxt = '0;
                        if (r_state == ST_PGRST) w_state_nxt = ST_IDLE;
                        else                     w_state_nxt = (r_nw == '0) ? ST_FIN : ST_ADDR;
                    end
                end
            end
            ST_IDLE: begin
                if (start) begin
                    w_nw_nxt  = w_nw_clamp;
                    w_bit_nxt = '0;
                    w_idx_nxt = '0;
                    if (rst_chip)                w_state_nxt = ST_GRST;
                    else if (w_nw_clamp == '0)   w_state_nxt = ST_FIN;
                    else                         w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_bit_end) begin
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == BIT_W'(ADDR_W - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == BIT_W'(DATA_W - 1)) begin
                        w_bit_nxt = '0;
                        if (GAP_BITS > 0) w_state_nxt = ST_GAP;
                        else              w_word_end  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_bit_end) begin
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == BIT_W'(GAP_BITS - 1)) w_word_end = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_word_end) begin
            w_bit_nxt = '0;
            if (w_last_word) begin
                w_state_nxt = ST_FIN;
                w_idx_nxt   = '0;
            end else begin
                w_state_nxt = ST_ADDR;
                w_idx_nxt   = r_idx + 1'b1;
            end
        end
    end

    // Forward a same-cycle table write so a run started alongside it
    // shifts the new value from its very first bit.
    always_comb begin
        w_entry      = (w_we && (tbl_addr == w_idx_nxt)) ? tbl_wdata : r_tbl[w_idx_nxt];
        w_slave      = w_entry[ENT_W-1 -: ADDR_W];
        w_data       = w_entry[DATA_W-1:0];
        w_aidx       = AI_W'(ADDR_W - 1) - AI_W'(w_bit_nxt);
        w_didx       = (DATA_MSB_FIRST != 0) ? (DI_W'(DATA_W - 1) - DI_W'(w_bit_nxt)) : DI_W'(w_bit_nxt);
        w_grst_nxt   = (w_state_nxt == ST_PGRST) || (w_state_nxt == ST_GRST);
        w_regsel_nxt = (w_state_nxt == ST_ADDR);
        w_sin_nxt    = 1'b0;
        if (w_state_nxt == ST_ADDR)      w_sin_nxt = w_slave[w_aidx];
        else if (w_state_nxt == ST_DATA) w_sin_nxt = w_data[w_didx];
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) r_state <= ST_PGRST;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            r_bit  <= '0;
            r_idx  <= '0;
            r_nw   <= '0;
            GRST   <= 1'b1;
            REGSEL <= 1'b0;
            SIN    <= 1'b0;
        end else begin
            r_bit  <= w_bit_nxt;
            r_idx  <= w_idx_nxt;
            r_nw   <= w_nw_nxt;
            GRST   <= w_grst_nxt;
            REGSEL <= w_regsel_nxt;
            SIN    <= w_sin_nxt;
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_WORDS; i++) r_tbl[i] <= '0;
        end else if (w_we) begin
            r_tbl[tbl_addr] <= tbl_wdata;
        end
    end

endmodule
`default_nettype wire
